trap_controller: RTL and testbench

//  Parametrised trap sequencer for the Mini-RISC-V core; generalises the single-IRQ trapping flag to NUM_IRQ sources.

---
 rtl/trap_controller.sv | 88 ++++++++
 tb/tb_trap_controller.sv | 100 ++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// trap_controller: arbitrates ecall and NUM_IRQ interrupt lines, latches mcause/mepc/handler target, and issues trap entry and return pulses. Ports: clk, Rst (sync, active-high), irq_in/irq_en/ecall/trap_ret/mem_hold/pc_in/mtvec in; trapping, trigger_trap, trigger_trap_ret, trap_target, mcause, mepc, irq_ack out.
module trap_controller #(
  parameter int NUM_IRQ = 4,
  parameter int XLEN = 32,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = NUM_IRQ'(1),
  parameter int IRQ_BASE = 16,
  parameter int ECALL_CAUSE = 11
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               ecall,
  input  logic               trap_ret,
  input  logic               mem_hold,
  input  logic [XLEN-1:0]    pc_in,
  input  logic [XLEN-1:0]    mtvec,
  output logic               trapping,
  output logic               trigger_trap,
  output logic               trigger_trap_ret,
  output logic [XLEN-1:0]    trap_target,
  output logic [XLEN-1:0]    mcause,
  output logic [XLEN-1:0]    mepc,
  output logic [NUM_IRQ-1:0] irq_ack
);
  typedef enum logic [1:0] {IDLE, ENTER, HANDLER, RETURN} state_t;
  state_t state, state_nx;
  logic [NUM_IRQ-1:0] irq_q, pend_r, rise, pend, req, sel, clr;
  logic [4:0] idx;
  logic take, ret_take;
  logic [XLEN-2:0] code;
  logic [XLEN-1:0] base, target;
  assign rise = irq_in & ~irq_q;
  // Edge sources see a rising edge in the same cycle, so entry latency matches level sources.
  assign pend = (EDGE_MASK & (pend_r | rise)) | (~EDGE_MASK & irq_in);
  assign req = pend & irq_en;
  always_comb begin
    sel = '0;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel = NUM_IRQ'(1) << i;
        idx = 5'(i);
      end
    end
  end
  assign take = state == IDLE && !mem_hold && (ecall || |req);
  assign ret_take = state == HANDLER && !mem_hold && trap_ret;
  assign clr = (take && !ecall) ? sel : '0;
  assign code = ecall ? (XLEN-1)'(ECALL_CAUSE) : (XLEN-1)'(IRQ_BASE) + (XLEN-1)'(idx);
  assign base = {mtvec[XLEN-1:2], 2'b00};
  assign target = base + ((mtvec[1:0] == 2'b01 && !ecall) ? {code[XLEN-3:0], 2'b00} : '0);
  always_comb begin
    state_nx = state;
    if (!mem_hold)
      state_nx = state == IDLE    ? (ecall || |req ? ENTER : IDLE) :
                 state == ENTER   ? HANDLER :
                 state == HANDLER ? (trap_ret ? RETURN : HANDLER) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (Rst) begin
      state <= IDLE;
      irq_q <= '0;
      pend_r <= '0;
      trapping <= 1'b0;
      trigger_trap <= 1'b0;
      trigger_trap_ret <= 1'b0;
      trap_target <= '0;
      mcause <= '0;
      mepc <= '0;
      irq_ack <= '0;
    end else begin
      state <= state_nx;
      irq_q <= irq_in;
      pend_r <= EDGE_MASK & (pend_r | rise) & ~clr;
      trigger_trap <= take;
      trigger_trap_ret <= ret_take;
      irq_ack <= clr;
      if (take) begin
        trapping <= 1'b1;
        mepc <= pc_in;
        mcause <= {~ecall, code};
        trap_target <= target;
      end
      if (ret_take) trapping <= 1'b0;
    end
  end
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: table-driven vectors with an expected-output queue for trap_controller.
module tb_trap_controller;
  logic clk = 1'b0, Rst;
  logic [3:0] irq_in, irq_en, irq_ack;
  logic ecall, trap_ret, mem_hold, trapping, trigger_trap, trigger_trap_ret;
  logic [31:0] pc_in, mtvec, trap_target, mcause, mepc;
  int applied = 0, miscompares = 0;
  typedef struct {
    logic rst; logic [3:0] irq, en; logic ec, ret, hold; logic [31:0] pc, tv;
    logic trap, tt, ttr; logic [3:0] ack; logic [31:0] cause, epc, tgt;
  } vec_t;
  typedef struct { logic trap, tt, ttr; logic [3:0] ack; logic [31:0] cause, epc, tgt; } exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  trap_controller #(.NUM_IRQ(4), .XLEN(32), .EDGE_MASK(4'b1001), .IRQ_BASE(16), .ECALL_CAUSE(11)) dut (
    .clk(clk), .Rst(Rst), .irq_in(irq_in), .irq_en(irq_en), .ecall(ecall), .trap_ret(trap_ret),
    .mem_hold(mem_hold), .pc_in(pc_in), .mtvec(mtvec), .trapping(trapping), .trigger_trap(trigger_trap),
    .trigger_trap_ret(trigger_trap_ret), .trap_target(trap_target), .mcause(mcause), .mepc(mepc), .irq_ack(irq_ack)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic rst, logic [3:0] irq, logic [3:0] en, logic ec, logic ret, logic hold,
                              logic [31:0] pc, logic [31:0] tv, logic trap, logic tt, logic ttr,
                              logic [3:0] ack, logic [31:0] cause, logic [31:0] epc, logic [31:0] tgt);
    vec_t v;
    v.rst = rst; v.irq = irq; v.en = en; v.ec = ec; v.ret = ret; v.hold = hold; v.pc = pc; v.tv = tv;
    v.trap = trap; v.tt = tt; v.ttr = ttr; v.ack = ack; v.cause = cause; v.epc = epc; v.tgt = tgt;
    return v;
  endfunction
  task automatic run(input vec_t v, input string name);
    exp_t e;
    Rst = v.rst; irq_in = v.irq; irq_en = v.en; ecall = v.ec; trap_ret = v.ret;
    mem_hold = v.hold; pc_in = v.pc; mtvec = v.tv;
    sb.push_back('{v.trap, v.tt, v.ttr, v.ack, v.cause, v.epc, v.tgt});
    @(posedge clk);
    #1;
    applied++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s: no expected entry queued", name);
    end else begin
      e = sb.pop_front();
      if ({trapping, trigger_trap, trigger_trap_ret, irq_ack, mcause, mepc, trap_target} !==
          {e.trap, e.tt, e.ttr, e.ack, e.cause, e.epc, e.tgt}) begin
        miscompares++;
        $display("FAIL %s: got trap=%b tt=%b ttr=%b ack=%h cause=%h epc=%h tgt=%h, want trap=%b tt=%b ttr=%b ack=%h cause=%h epc=%h tgt=%h",
                 name, trapping, trigger_trap, trigger_trap_ret, irq_ack, mcause, mepc, trap_target,
                 e.trap, e.tt, e.ttr, e.ack, e.cause, e.epc, e.tgt);
      end
    end
  endtask
  initial begin
    Rst = 1'b1; irq_in = '0; irq_en = '0; ecall = 0; trap_ret = 0; mem_hold = 0; pc_in = '0; mtvec = '0;
    tbl.push_back(mk(1, 4'h0, 4'hF, 0, 0, 0, 'h40, 'h100, 0, 0, 0, 4'h0, 'h0, 'h0, 'h0));
    tbl.push_back(mk(0, 4'h1, 4'hF, 0, 0, 0, 'h40, 'h100, 1, 1, 0, 4'h1, 'h80000010, 'h40, 'h100));
    tbl.push_back(mk(0, 4'h1, 4'hF, 0, 0, 0, 'h40, 'h100, 1, 0, 0, 4'h0, 'h80000010, 'h40, 'h100));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 1, 0, 'h40, 'h100, 0, 0, 1, 4'h0, 'h80000010, 'h40, 'h100));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 'h40, 'h100, 0, 0, 0, 4'h0, 'h80000010, 'h40, 'h100));
    tbl.push_back(mk(0, 4'h4, 4'hF, 0, 0, 0, 'h80, 'h101, 1, 1, 0, 4'h4, 'h80000012, 'h80, 'h148));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 'h80, 'h101, 1, 0, 0, 4'h0, 'h80000012, 'h80, 'h148));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 1, 0, 'h80, 'h101, 0, 0, 1, 4'h0, 'h80000012, 'h80, 'h148));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 'h80, 'h101, 0, 0, 0, 4'h0, 'h80000012, 'h80, 'h148));
    tbl.push_back(mk(0, 4'h2, 4'hF, 1, 0, 0, 'hC0, 'h101, 1, 1, 0, 4'h0, 'h0000000B, 'hC0, 'h100));
    tbl.push_back(mk(0, 4'h2, 4'hF, 0, 0, 0, 'hC0, 'h101, 1, 0, 0, 4'h0, 'h0000000B, 'hC0, 'h100));
    tbl.push_back(mk(0, 4'h2, 4'hF, 0, 1, 0, 'hC0, 'h101, 0, 0, 1, 4'h0, 'h0000000B, 'hC0, 'h100));
    tbl.push_back(mk(0, 4'h2, 4'hF, 0, 0, 0, 'hC0, 'h101, 0, 0, 0, 4'h0, 'h0000000B, 'hC0, 'h100));
    tbl.push_back(mk(0, 4'h2, 4'hF, 0, 0, 0, 'h100, 'h101, 1, 1, 0, 4'h2, 'h80000011, 'h100, 'h144));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 'h100, 'h101, 1, 0, 0, 4'h0, 'h80000011, 'h100, 'h144));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 1, 0, 'h100, 'h101, 0, 0, 1, 4'h0, 'h80000011, 'h100, 'h144));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 1, 0, 'h100, 'h101, 0, 0, 0, 4'h0, 'h80000011, 'h100, 'h144));
    tbl.push_back(mk(0, 4'h1, 4'hF, 0, 0, 0, 'h40, 'h100, 1, 1, 0, 4'h1, 'h80000010, 'h40, 'h100));
    tbl.push_back(mk(0, 4'h8, 4'hF, 0, 0, 0, 'h40, 'h100, 1, 0, 0, 4'h0, 'h80000010, 'h40, 'h100));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 'h40, 'h100, 1, 0, 0, 4'h0, 'h80000010, 'h40, 'h100));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 1, 0, 'h40, 'h100, 0, 0, 1, 4'h0, 'h80000010, 'h40, 'h100));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 'h40, 'h100, 0, 0, 0, 4'h0, 'h80000010, 'h40, 'h100));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 'h200, 'h100, 1, 1, 0, 4'h8, 'h80000013, 'h200, 'h100));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 'h200, 'h100, 1, 0, 0, 4'h0, 'h80000013, 'h200, 'h100));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 1, 0, 'h200, 'h100, 0, 0, 1, 4'h0, 'h80000013, 'h200, 'h100));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 'h200, 'h100, 0, 0, 0, 4'h0, 'h80000013, 'h200, 'h100));
    tbl.push_back(mk(0, 4'h1, 4'hE, 0, 0, 0, 'h40, 'h100, 0, 0, 0, 4'h0, 'h80000013, 'h200, 'h100));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 'h40, 'h100, 1, 1, 0, 4'h1, 'h80000010, 'h40, 'h100));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 'h40, 'h100, 1, 0, 0, 4'h0, 'h80000010, 'h40, 'h100));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 1, 0, 'h40, 'h100, 0, 0, 1, 4'h0, 'h80000010, 'h40, 'h100));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 'h40, 'h100, 0, 0, 0, 4'h0, 'h80000010, 'h40, 'h100));
    for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 3; i++)
      run(mk(0, 4'h4, 4'hF, 0, 0, 1, 'h300, 'h100, 0, 0, 0, 4'h0, 'h80000010, 'h40, 'h100), "hold_idle");
    run(mk(0, 4'h4, 4'hF, 0, 0, 0, 'h300, 'h100, 1, 1, 0, 4'h4, 'h80000012, 'h300, 'h100), "hold_release");
    run(mk(0, 4'h0, 4'hF, 0, 0, 0, 'h300, 'h100, 1, 0, 0, 4'h0, 'h80000012, 'h300, 'h100), "single_pulse");
    run(mk(0, 4'h0, 4'hF, 0, 1, 1, 'h300, 'h100, 1, 0, 0, 4'h0, 'h80000012, 'h300, 'h100), "hold_ret");
    run(mk(0, 4'h0, 4'hF, 0, 1, 0, 'h300, 'h100, 0, 0, 1, 4'h0, 'h80000012, 'h300, 'h100), "ret_after_hold");
    run(mk(0, 4'h0, 4'hF, 0, 0, 0, 'h300, 'h100, 0, 0, 0, 4'h0, 'h80000012, 'h300, 'h100), "back_idle");
    run(mk(0, 4'h0, 4'hF, 1, 0, 0, 'h40, 'h100, 1, 1, 0, 4'h0, 'h0000000B, 'h40, 'h100), "rst_entry");
    run(mk(0, 4'h8, 4'hF, 0, 0, 0, 'h40, 'h100, 1, 0, 0, 4'h0, 'h0000000B, 'h40, 'h100), "rst_handler");
    run(mk(1, 4'h0, 4'hF, 0, 0, 0, 'h40, 'h100, 0, 0, 0, 4'h0, 'h0, 'h0, 'h0), "rst_abort");
    run(mk(0, 4'h0, 4'hF, 0, 1, 0, 'h40, 'h100, 0, 0, 0, 4'h0, 'h0, 'h0, 'h0), "ret_ignored");
    run(mk(0, 4'h0, 4'hF, 0, 0, 0, 'h40, 'h100, 0, 0, 0, 4'h0, 'h0, 'h0, 'h0), "pend_cleared");
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
